// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver state encoding and elaboration-time sizing helpers.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_PUSH      = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } rx_state_t;

    // One FIFO entry carries {break, ferr, perr, data}
    function automatic int entry_width(input int data_bits);
        return data_bits + 3;
    endfunction

    // Clocks per oversample tick; never below one so the tick always fires
    function automatic int prescale(input int clk_freq, input int baud_rate, input int oversample);
        int p;
        p = clk_freq / (baud_rate * oversample);
        return (p < 1) ? 1 : p;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head entry is
// presented on o_rdata whenever the FIFO is not empty and reads as zero
// when empty. Pointers carry an extra wrap bit to tell full from empty.
module uart_rx_fifo
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~w_empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Read and write pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset because emptiness gates the output
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with 3-sample majority vote,
// optional parity, 1 or 2 stop bits, break detection and a small FWFT
// receive FIFO with a sticky overrun flag.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pad,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_perr,
    output logic                 rd_ferr,
    output logic                 rd_break,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 busy
);

    localparam int PRESCALE = prescale(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int MID      = OVERSAMPLE / 2;
    localparam int BW       = $clog2(DATA_BITS);
    localparam int EW       = entry_width(DATA_BITS);

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_VOTE0   = SW'(MID - 1);
    localparam logic [SW-1:0] S_VOTE1   = SW'(MID);
    localparam logic [SW-1:0] S_RESOLVE = SW'(MID + 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD_SEL   = (PARITY == PAR_ODD);
    localparam logic          HAS_PAR   = (PARITY != PAR_NONE);

    // Input conditioning
    logic r_sync1;
    logic r_sync2;
    logic r_hist;
    logic w_start_edge;

    // Bit timing
    logic [PW-1:0] r_pre;
    logic [SW-1:0] r_scnt;
    logic          w_tick;
    logic          w_res_tick;
    logic          w_end_tick;
    logic          r_s0;
    logic          r_s1;
    logic          w_maj;

    // Character assembly
    rx_state_t            r_state;
    logic [BW-1:0]        r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parbit;
    logic                 r_ferr;
    logic                 w_perr;
    logic                 w_brk;

    // FIFO side
    logic          w_push;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_rdata;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          r_overrun;

    // Two-flop synchroniser for the asynchronous pad, plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= pad;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_start_edge = (r_state == ST_IDLE) & r_hist & ~r_sync2;

    assign w_tick     = (r_pre == PRE_LAST);
    assign w_res_tick = w_tick & (r_scnt == S_RESOLVE);
    assign w_end_tick = w_tick & (r_scnt == S_LAST);

    // Prescaler and per-bit sample counter, both realigned to the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_scnt <= '0;
        end else if (w_start_edge) begin
            r_pre  <= '0;
            r_scnt <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick) begin
                r_scnt <= (r_scnt == S_LAST) ? '0 : r_scnt + SW'(1);
            end
        end
    end

    // Capture the first two of the three mid-bit votes; the third is taken live on resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else if (w_tick) begin
            if (r_scnt == S_VOTE0) begin
                r_s0 <= r_sync2;
            end
            if (r_scnt == S_VOTE1) begin
                r_s1 <= r_sync2;
            end
        end
    end

    assign w_maj = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

    // Receiver FSM: frames the character and collects its status bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_parbit <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_state  <= ST_START;
                        r_bitcnt <= '0;
                        r_parbit <= 1'b0;
                        r_ferr   <= 1'b0;
                    end
                end
                ST_START: begin
                    // A start bit that reads high at mid-bit was a glitch
                    if (w_res_tick && w_maj) begin
                        r_state <= ST_IDLE;
                    end else if (w_end_tick) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_res_tick) begin
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_end_tick) begin
                        if (r_bitcnt == DATA_LAST) begin
                            r_bitcnt <= '0;
                            r_state  <= HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bitcnt <= r_bitcnt + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_res_tick) begin
                        r_parbit <= w_maj;
                    end
                    if (w_end_tick) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leave at mid-point of the last stop bit so a back-to-back start edge is seen
                    if (w_res_tick) begin
                        if (!w_maj) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_bitcnt == STOP_LAST) begin
                            r_state <= ST_PUSH;
                        end
                    end
                    if (w_end_tick) begin
                        r_bitcnt <= r_bitcnt + BW'(1);
                    end
                end
                ST_PUSH: begin
                    // After a framing error the line may still be low; wait for it to recover
                    r_state <= r_ferr ? ST_WAIT_HIGH : ST_IDLE;
                end
                ST_WAIT_HIGH: begin
                    if (r_sync2) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_perr  = HAS_PAR & (((^r_shift) ^ r_parbit) != ODD_SEL);
    assign w_brk   = r_ferr & (r_shift == '0) & (~r_parbit | ~HAS_PAR);
    assign w_push  = (r_state == ST_PUSH);
    assign w_wdata = {w_brk, r_ferr, w_perr, r_shift};
    assign w_pop   = ~w_empty & rd_ready;

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_empty (w_empty)
    );

    // Sticky overrun: a new drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign rd_data  = w_rdata[DATA_BITS-1:0];
    assign rd_perr  = w_rdata[DATA_BITS];
    assign rd_ferr  = w_rdata[DATA_BITS+1];
    assign rd_break = w_rdata[DATA_BITS+2];
    assign rd_valid = ~w_empty;
    assign overrun  = r_overrun;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E1 instance, both at
// 16 clocks per bit. Table-driven character vectors plus hand-written
// sequences for glitch, break, overrun and mid-character reset.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int CLKF   = 1843200;
    localparam int BAUD   = 115200;
    localparam int OS     = 16;
    localparam int BITCLK = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       pad8, rd_ready8, clr8;
    logic [7:0] rd_data8;
    logic       perr8, ferr8, brk8, valid8, ovr8, busy8;
    logic       pad7, rd_ready7, clr7;
    logic [6:0] rd_data7;
    logic       perr7, ferr7, brk7, valid7, ovr7, busy7;

    uart_rx_cfg #(
        .CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut8 (
        .clk(clk), .rst_n(rst_n), .pad(pad8), .rd_data(rd_data8), .rd_perr(perr8),
        .rd_ferr(ferr8), .rd_break(brk8), .rd_valid(valid8), .rd_ready(rd_ready8),
        .overrun(ovr8), .clr_overrun(clr8), .busy(busy8)
    );

    uart_rx_cfg #(
        .CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(7),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut7 (
        .clk(clk), .rst_n(rst_n), .pad(pad7), .rd_data(rd_data7), .rd_perr(perr7),
        .rd_ferr(ferr7), .rd_break(brk7), .rd_valid(valid7), .rd_ready(rd_ready7),
        .overrun(ovr7), .clr_overrun(clr7), .busy(busy7)
    );

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    typedef struct {
        bit         sel7;
        logic [8:0] data;
        logic       parbit;
        bit         hold;
        logic       exp_perr;
    } vec_t;

    exp_t q8[$];
    exp_t q7[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic drive_bit(input bit sel7, input logic v);
        @(posedge clk);
        #1;
        if (sel7) pad7 = v;
        else      pad8 = v;
        repeat (BITCLK - 1) @(posedge clk);
    endtask

    task automatic send_char(input bit sel7, input logic [8:0] data, input int nbits,
                             input bit use_par, input logic parbit);
        drive_bit(sel7, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel7, data[i]);
        if (use_par) drive_bit(sel7, parbit);
        drive_bit(sel7, 1'b1);
    endtask

    task automatic expect_char(input bit sel7, input logic [8:0] data, input logic perr,
                               input logic ferr, input logic brk);
        exp_t e;
        e.data = data; e.perr = perr; e.ferr = ferr; e.brk = brk;
        if (sel7) q7.push_back(e);
        else      q8.push_back(e);
    endtask

    // Wait for the DUT head entry, compare with the scoreboard, then pop it
    task automatic pop(input bit sel7, input string tag);
        exp_t e;
        int   cnt;
        logic v;
        if ((sel7 && q7.size() == 0) || (!sel7 && q8.size() == 0)) begin
            n_checks++;
            $display("FAIL %s: pop requested with empty scoreboard", tag);
            return;
        end
        if (sel7) e = q7.pop_front();
        else      e = q8.pop_front();
        cnt = 0;
        @(negedge clk);
        v = sel7 ? valid7 : valid8;
        while (!v && cnt < 400) begin
            @(negedge clk);
            cnt++;
            v = sel7 ? valid7 : valid8;
        end
        if (!v) begin
            chk({tag, "_timeout_valid"}, 32'(v), 32'd1);
            return;
        end
        chk({tag, "_data"}, sel7 ? 32'(rd_data7) : 32'(rd_data8), 32'(e.data));
        chk({tag, "_perr"}, sel7 ? 32'(perr7) : 32'(perr8), 32'(e.perr));
        chk({tag, "_ferr"}, sel7 ? 32'(ferr7) : 32'(ferr8), 32'(e.ferr));
        chk({tag, "_break"}, sel7 ? 32'(brk7) : 32'(brk8), 32'(e.brk));
        if (sel7) rd_ready7 = 1'b1;
        else      rd_ready8 = 1'b1;
        @(posedge clk);
        #1;
        rd_ready7 = 1'b0;
        rd_ready8 = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ovr_chars [5];
        int         cnt;

        vecs[0] = '{1'b0, 9'h0A5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 9'h03C, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 9'h0FF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 9'h001, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 9'h080, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 9'h041, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 9'h041, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 9'h043, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 9'h07F, 1'b1, 1'b0, 1'b0};
        ovr_chars = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst_n = 1'b0;
        pad8 = 1'b1; pad7 = 1'b1;
        rd_ready8 = 1'b0; rd_ready7 = 1'b0;
        clr8 = 1'b0; clr7 = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_rd_data", 32'(rd_data8), 32'd0);
        chk("reset_rd_perr", 32'(perr8), 32'd0);
        chk("reset_rd_ferr", 32'(ferr8), 32'd0);
        chk("reset_rd_break", 32'(brk8), 32'd0);
        chk("reset_rd_valid", 32'(valid8), 32'd0);
        chk("reset_overrun", 32'(ovr8), 32'd0);
        chk("reset_busy", 32'(busy8), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Character table: back-to-back 8N1 pairs and 7E1 parity cases
        foreach (vecs[i]) begin
            send_char(vecs[i].sel7, vecs[i].data, vecs[i].sel7 ? 7 : 8, vecs[i].sel7, vecs[i].parbit);
            expect_char(vecs[i].sel7, vecs[i].data, vecs[i].exp_perr, 1'b0, 1'b0);
            if (!vecs[i].hold) begin
                while (vecs[i].sel7 ? (q7.size() != 0) : (q8.size() != 0))
                    pop(vecs[i].sel7, $sformatf("vec%0d", i));
            end
        end
        @(negedge clk);
        chk("table_no_overrun", 32'(ovr8), 32'd0);
        chk("table_drained", 32'(valid8), 32'd0);

        // Glitch shorter than half a bit is rejected
        @(posedge clk); #1 pad8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 pad8 = 1'b1;
        chk("glitch_busy_set", 32'(busy8), 32'd1);
        cnt = 0;
        while (busy8 && cnt < 12) begin
            @(negedge clk);
            cnt++;
        end
        chk("glitch_busy_clear", 32'(busy8), 32'd0);
        repeat (40) @(negedge clk);
        chk("glitch_no_push", 32'(valid8), 32'd0);

        // Break: line held low for 30 bit-times
        @(posedge clk); #1 pad8 = 1'b0;
        expect_char(1'b0, 9'h000, 1'b0, 1'b1, 1'b1);
        pop(1'b0, "break");
        repeat (340) @(negedge clk);
        chk("break_single_entry", 32'(valid8), 32'd0);
        chk("break_wait_high_busy", 32'(busy8), 32'd1);
        @(posedge clk); #1 pad8 = 1'b1;
        repeat (10) @(negedge clk);
        chk("break_release_idle", 32'(busy8), 32'd0);
        chk("break_release_no_entry", 32'(valid8), 32'd0);
        send_char(1'b0, 9'h05A, 8, 1'b0, 1'b0);
        expect_char(1'b0, 9'h05A, 1'b0, 1'b0, 1'b0);
        pop(1'b0, "after_break");

        // Overrun: five characters into a four-entry FIFO with no reads
        for (int i = 0; i < 5; i++) begin
            send_char(1'b0, {1'b0, ovr_chars[i]}, 8, 1'b0, 1'b0);
            if (i < 4) expect_char(1'b0, {1'b0, ovr_chars[i]}, 1'b0, 1'b0, 1'b0);
        end
        repeat (5) @(negedge clk);
        chk("ovr_valid", 32'(valid8), 32'd1);
        chk("ovr_head", 32'(rd_data8), 32'h11);
        chk("ovr_flag_set", 32'(ovr8), 32'd1);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        @(negedge clk);
        chk("ovr_flag_cleared", 32'(ovr8), 32'd0);
        for (int i = 0; i < 4; i++) pop(1'b0, $sformatf("ovr_pop%0d", i));
        @(negedge clk);
        chk("ovr_drained", 32'(valid8), 32'd0);

        // Reset in the middle of a character with an entry already queued
        send_char(1'b0, 9'h077, 8, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        @(negedge clk);
        chk("midchar_busy", 32'(busy8), 32'd1);
        chk("midchar_valid", 32'(valid8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(valid8), 32'd0);
        chk("rst_async_data", 32'(rd_data8), 32'd0);
        chk("rst_async_busy", 32'(busy8), 32'd0);
        chk("rst_async_status", 32'({perr8, ferr8, brk8, ovr8}), 32'd0);
        pad8 = 1'b1;
        q8.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_char(1'b0, 9'h055, 8, 1'b0, 1'b0);
        expect_char(1'b0, 9'h055, 1'b0, 1'b0, 1'b0);
        pop(1'b0, "post_reset");
        repeat (200) @(negedge clk);
        chk("post_reset_one_entry", 32'(valid8), 32'd0);
        chk("post_reset_idle", 32'(busy8), 32'd0);
        chk("dut7_idle", 32'({busy7, ovr7, valid7}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
